// File: rtl/reference_model.sv
// Register-access decoder for the 8237-style DMA controller: turns CPU bus accesses into one-cycle register strobes.
// Optional macro REF_MODEL_TEMP_READ_EN enables the readTemporaryReg strobe on a read of 0xD.
module reference_model #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              programCondition,
  input  logic              CS_N,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic [ADDR_W-1:0] A,
  output logic              loadCommandReg,
  output logic              loadModeReg,
  output logic              loadRequestReg,
  output logic              loadSingleMask,
  output logic              loadAllMask,
  output logic              clearMaskReg,
  output logic              clearFF,
  output logic              masterClear,
  output logic              loadBaseAddressReg,
  output logic              loadBaseWordCountReg,
  output logic              readStatusReg,
  output logic              readTemporaryReg,
  output logic              readCurrentAddressReg,
  output logic              readCurrentWordCountReg,
  output logic [1:0]        channel,
  output logic              byteSel,
  output logic              busError
);

  localparam int unsigned SEL_W     = 4;
  localparam int unsigned STROBE_W  = 14;
  localparam int unsigned S_CMD     = 0;
  localparam int unsigned S_MODE    = 1;
  localparam int unsigned S_REQ     = 2;
  localparam int unsigned S_SMASK   = 3;
  localparam int unsigned S_AMASK   = 4;
  localparam int unsigned S_CMASK   = 5;
  localparam int unsigned S_CLRFF   = 6;
  localparam int unsigned S_MCLR    = 7;
  localparam int unsigned S_BADDR   = 8;
  localparam int unsigned S_BCOUNT  = 9;
  localparam int unsigned S_STATUS  = 10;
  localparam int unsigned S_TEMP    = 11;
  localparam int unsigned S_CADDR   = 12;
  localparam int unsigned S_CCOUNT  = 13;

  logic [SEL_W-1:0]    sel;
  logic                isValid;
  logic                isWrite;
  logic                isConflict;
  logic                isStart;

  logic                prevValid;
  logic                prevWrite;
  logic                prevConflict;
  logic                armed;
  logic                pointer;
  logic [STROBE_W-1:0] strobeQ;

  logic [STROBE_W-1:0] strobeNext;
  logic                pointerNext;
  logic [1:0]          channelNext;
  logic                byteSelNext;
  logic                busErrorNext;

  assign sel        = A[SEL_W-1:0];
  assign isValid    = programCondition & ~CS_N & (IOR_N ^ IOW_N);
  assign isWrite    = ~IOW_N;
  assign isConflict = programCondition & ~CS_N & ~IOR_N & ~IOW_N;
  // A start needs a fresh edge: idle before, or a direction flip; armed blocks accesses held across reset.
  assign isStart    = isValid & armed & (~prevValid | (prevWrite != isWrite));

  // Decode the access start into one strobe and update the byte pointer.
  always_comb begin
    strobeNext   = '0;
    pointerNext  = pointer;
    channelNext  = channel;
    byteSelNext  = byteSel;
    busErrorNext = isConflict & ~prevConflict;
    if (isStart) begin
      if (!sel[3]) begin
        channelNext = sel[2:1];
        byteSelNext = pointer;
        pointerNext = ~pointer;
        if (isWrite) begin
          if (sel[0]) strobeNext[S_BCOUNT] = 1'b1;
          else        strobeNext[S_BADDR]  = 1'b1;
        end else begin
          if (sel[0]) strobeNext[S_CCOUNT] = 1'b1;
          else        strobeNext[S_CADDR]  = 1'b1;
        end
      end else if (isWrite) begin
        case (sel[2:0])
          3'd0: strobeNext[S_CMD]   = 1'b1;
          3'd1: strobeNext[S_REQ]   = 1'b1;
          3'd2: strobeNext[S_SMASK] = 1'b1;
          3'd3: strobeNext[S_MODE]  = 1'b1;
          3'd4: begin
            strobeNext[S_CLRFF] = 1'b1;
            pointerNext         = 1'b0;
          end
          3'd5: begin
            strobeNext[S_MCLR] = 1'b1;
            pointerNext        = 1'b0;
          end
          3'd6: strobeNext[S_CMASK] = 1'b1;
          default: strobeNext[S_AMASK] = 1'b1;
        endcase
      end else begin
        case (sel[2:0])
          3'd0: strobeNext[S_STATUS] = 1'b1;
`ifdef REF_MODEL_TEMP_READ_EN
          3'd5: strobeNext[S_TEMP]   = 1'b1;
`endif
          default: strobeNext = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prevValid    <= 1'b0;
      prevWrite    <= 1'b0;
      prevConflict <= 1'b0;
      armed        <= 1'b0;
      pointer      <= 1'b0;
      strobeQ      <= '0;
      channel      <= 2'd0;
      byteSel      <= 1'b0;
      busError     <= 1'b0;
    end else begin
      prevValid    <= isValid;
      prevWrite    <= isWrite;
      prevConflict <= isConflict;
      armed        <= armed | ~isValid;
      pointer      <= pointerNext;
      strobeQ      <= strobeNext;
      channel      <= channelNext;
      byteSel      <= byteSelNext;
      busError     <= busErrorNext;
    end
  end

  assign loadCommandReg          = strobeQ[S_CMD];
  assign loadModeReg             = strobeQ[S_MODE];
  assign loadRequestReg          = strobeQ[S_REQ];
  assign loadSingleMask          = strobeQ[S_SMASK];
  assign loadAllMask             = strobeQ[S_AMASK];
  assign clearMaskReg            = strobeQ[S_CMASK];
  assign clearFF                 = strobeQ[S_CLRFF];
  assign masterClear             = strobeQ[S_MCLR];
  assign loadBaseAddressReg      = strobeQ[S_BADDR];
  assign loadBaseWordCountReg    = strobeQ[S_BCOUNT];
  assign readStatusReg           = strobeQ[S_STATUS];
  assign readTemporaryReg        = strobeQ[S_TEMP];
  assign readCurrentAddressReg   = strobeQ[S_CADDR];
  assign readCurrentWordCountReg = strobeQ[S_CCOUNT];

endmodule

// File: tb/tb_reference_model.sv
// Bench for reference_model: directed scenarios plus randomized bus traffic checked against a table-driven model.
module tb_reference_model;

  logic       CLK;
  logic       RESET_N;
  logic       programCondition;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask;
  logic clearMaskReg, clearFF, masterClear, loadBaseAddressReg, loadBaseWordCountReg;
  logic readStatusReg, readTemporaryReg, readCurrentAddressReg, readCurrentWordCountReg;
  logic [1:0] channel;
  logic       byteSel;
  logic       busError;

  reference_model #(.ADDR_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .programCondition(programCondition),
    .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
    .loadCommandReg(loadCommandReg), .loadModeReg(loadModeReg),
    .loadRequestReg(loadRequestReg), .loadSingleMask(loadSingleMask),
    .loadAllMask(loadAllMask), .clearMaskReg(clearMaskReg), .clearFF(clearFF),
    .masterClear(masterClear), .loadBaseAddressReg(loadBaseAddressReg),
    .loadBaseWordCountReg(loadBaseWordCountReg), .readStatusReg(readStatusReg),
    .readTemporaryReg(readTemporaryReg), .readCurrentAddressReg(readCurrentAddressReg),
    .readCurrentWordCountReg(readCurrentWordCountReg), .channel(channel),
    .byteSel(byteSel), .busError(busError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit positions of the strobe vector; the model's address tables index into these.
  logic [13:0] dutStrobes;
  assign dutStrobes = {readCurrentWordCountReg, readCurrentAddressReg, readTemporaryReg,
                       readStatusReg, loadBaseWordCountReg, loadBaseAddressReg, masterClear,
                       clearFF, clearMaskReg, clearMaskReg ? 1'b0 : 1'b0, loadSingleMask,
                       loadRequestReg, loadModeReg, loadCommandReg} |
                      {9'd0, loadAllMask, 4'd0};

  int writeMap [16];
  int readMap  [16];

  int compared   = 0;
  int mismatched = 0;
  int cmdPulses  = 0;

  // Model state, described in bus-transaction terms.
  int          lastKind;       // 0 none, 1 read, 2 write
  bit          lastConflict;
  bit          mArmed;
  bit          mPtr;
  bit [1:0]    mChan;
  bit          mBsel;
  bit [13:0]   expStrobes;
  bit          expBus;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    check("strobes", 32'(dutStrobes), 32'(expStrobes));
    check("channel", 32'(channel), 32'(mChan));
    check("byteSel", 32'(byteSel), 32'(mBsel));
    check("busError", 32'(busError), 32'(expBus));
  endtask

  task automatic modelReset();
    lastKind = 0; lastConflict = 0; mArmed = 0; mPtr = 0;
    mChan = 2'd0; mBsel = 0; expStrobes = '0; expBus = 0;
  endtask

  // One clock of the bus as seen by the CPU-side protocol rules.
  task automatic modelStep();
    bit valid, conflict;
    int kind, idx, addr;
    valid    = programCondition && !CS_N && (IOR_N != IOW_N);
    conflict = programCondition && !CS_N && !IOR_N && !IOW_N;
    kind     = valid ? (!IOW_N ? 2 : 1) : 0;
    addr     = int'(A);
    expStrobes = '0;
    expBus     = conflict && !lastConflict;
    if (valid && mArmed && kind != lastKind) begin
      idx = (kind == 2) ? writeMap[addr] : readMap[addr];
      if (idx >= 0) expStrobes[idx] = 1'b1;
      if (addr < 8) begin
        mChan = 2'((addr / 2) % 4);
        mBsel = mPtr;
        mPtr  = !mPtr;
      end else if (kind == 2 && (addr == 12 || addr == 13)) begin
        mPtr = 0;
      end
    end
    if (!valid) mArmed = 1;
    lastKind     = kind;
    lastConflict = conflict;
  endtask

  task automatic cycle(input bit pc, input bit cs, input bit ior, input bit iow, input logic [3:0] a);
    @(negedge CLK);
    checkOutputs();
    if (loadCommandReg) cmdPulses++;
    programCondition = pc; CS_N = cs; IOR_N = ior; IOW_N = iow; A = a;
    modelStep();
  endtask

  // Assert reset between edges, verify the immediate clear, then release with the bus unchanged.
  task automatic applyReset(input int holdCycles);
    @(negedge CLK);
    RESET_N = 1'b0;
    modelReset();
    #1;
    checkOutputs();
    repeat (holdCycles) @(negedge CLK);
    RESET_N = 1'b1;
    modelStep();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1, 1, 1, 1, 4'h0);
  endtask

  initial begin
    writeMap = '{8, 9, 8, 9, 8, 9, 8, 9, 0, 2, 3, 1, 6, 7, 5, 4};
`ifdef REF_MODEL_TEMP_READ_EN
    readMap  = '{12, 13, 12, 13, 12, 13, 12, 13, 10, -1, -1, -1, -1, 11, -1, -1};
`else
    readMap  = '{12, 13, 12, 13, 12, 13, 12, 13, 10, -1, -1, -1, -1, -1, -1, -1};
`endif
    RESET_N = 1'b0; programCondition = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0;
    modelReset();
    #12;
    checkOutputs();
    applyReset(1);
    idle(3);

    // Held write to the command register gives exactly one pulse.
    cmdPulses = 0;
    repeat (3) cycle(1, 0, 1, 0, 4'h8);
    idle(2);
    check("cmdPulses", 32'(cmdPulses), 32'd1);

    // Byte pointer toggling, clear, and reading back.
    cycle(1, 0, 1, 0, 4'h2); idle(1);
    cycle(1, 0, 1, 0, 4'h2); idle(1);
    cycle(1, 0, 1, 0, 4'hC); idle(1);
    cycle(1, 0, 0, 1, 4'h2); idle(1);
    cycle(1, 0, 0, 1, 4'h8); idle(1);
    cycle(1, 0, 0, 1, 4'hD); idle(1);
    // Direction change without an idle cycle is a new start.
    cycle(1, 0, 0, 1, 4'h5); cycle(1, 0, 1, 0, 4'h5); idle(2);

    // Gated write, then bus conflict.
    repeat (2) cycle(0, 0, 1, 0, 4'hB);
    idle(1);
    repeat (2) cycle(1, 0, 0, 0, 4'h3);
    idle(2);

    // Reset in the cycle the strobe would be visible, with the write still held.
    cycle(1, 0, 1, 0, 4'h1);
    applyReset(0);
    cycle(1, 0, 1, 0, 4'h1);
    idle(1);
    cycle(1, 0, 1, 0, 4'h0); idle(2);

    // Randomized traffic with held phases and occasional resets.
    for (int i = 0; i < 500; i++) begin
      bit pc, cs, ior, iow;
      int kind, hold;
      logic [3:0] a;
      pc   = ($urandom_range(0, 9) != 0);
      cs   = ($urandom_range(0, 7) == 0);
      kind = $urandom_range(0, 9);
      ior  = !(kind <= 3 || kind == 9);
      iow  = !((kind >= 4 && kind <= 7) || kind == 9);
      a    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      if ($urandom_range(0, 99) == 0) applyReset($urandom_range(0, 2));
      repeat (hold) cycle(pc, cs, ior, iow, a);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
